// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run monitor.
// State encoding, saturating increment, default completion marker.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam int DEF_DONE_REG   = 1;
    localparam int DEF_DONE_VALUE = 1;

    // Works on a 64-bit carrier; w selects the live width (1..64).
    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int unsigned w
    );
        logic [63:0] top;
        top = {64{1'b1}} >> (64 - w);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
    import run_monitor_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] nxt;

    assign nxt = W'(sat_inc(64'(q), W));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: snoops regfile writes, detects completion, freezes results.
// Define RUN_MONITOR_TIMEOUT_EN to add the cycle-limit TIMEOUT exit.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int DONE_REG    = DEF_DONE_REG,
    parameter int DONE_VALUE  = DEF_DONE_VALUE,
    parameter int RES_BASE    = 2,
    parameter int NUM_RES     = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      retire,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [NUM_RES*DATA_W-1:0] result,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          instr_count
);

    state_t state;
    state_t nxt_state;

    logic in_run;
    logic arm;
    logic fin;
    logic snoop;
    int   idx;

    logic [NUM_RES-1:0][DATA_W-1:0] shadow;

    assign in_run = (state == RUN);
    assign arm    = start && !in_run;
    assign fin    = in_run && wr_en
                 && (wr_addr == ADDR_W'(DONE_REG))
                 && (wr_data == DATA_W'(DONE_VALUE));
    assign idx    = int'(wr_addr) - RES_BASE;
    // x0 is hardwired zero, so a write to it never reaches a slot.
    assign snoop  = in_run && wr_en && (wr_addr != '0)
                 && (idx >= 0) && (idx < NUM_RES);

`ifdef RUN_MONITOR_TIMEOUT_EN
    localparam logic [63:0] CMAX = {64{1'b1}} >> (64 - CNT_W);
    localparam bit TO_OK = (TIMEOUT_CYC >= 1)
                        && (64'(TIMEOUT_CYC - 1) < CMAX);

    logic to_hit;
    // Fires in the RUN cycle whose increment lands on the limit.
    assign to_hit = TO_OK && in_run
                 && (cycle_count == CNT_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE: begin
                if (start) nxt_state = RUN;
            end
            RUN: begin
                if (fin) begin
                    nxt_state = DONE;
                end
`ifdef RUN_MONITOR_TIMEOUT_EN
                else if (to_hit) begin
                    nxt_state = TIMEOUT;
                end
`endif
            end
            DONE, TIMEOUT: begin
                if (start) nxt_state = RUN;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
`ifdef RUN_MONITOR_TIMEOUT_EN
        timeout = (state == TIMEOUT);
`else
        timeout = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            shadow <= '0;
        end else if (snoop) begin
            for (int k = 0; k < NUM_RES; k++) begin
                if (idx == k) shadow[k] <= wr_data;
            end
        end
    end

    assign result = shadow;

    sat_counter #(.W(CNT_W)) u_cyc (
        .clk (clk),
        .rst (rst),
        .clr (arm),
        .inc (in_run),
        .q   (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_ins (
        .clk (clk),
        .rst (rst),
        .clr (arm),
        .inc (in_run && retire),
        .q   (instr_count)
    );

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: spec-level model plus directed literals.
// Honours RUN_MONITOR_TIMEOUT_EN when the design is built with it.
module tb_run_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        retire;

    logic        busy_a, done_a, to_a;
    logic [63:0] res_a;
    logic [31:0] cyc_a, ins_a;

    logic        busy_b, done_b, to_b;
    logic [63:0] res_b;
    logic [3:0]  cyc_b, ins_b;

    always #5 clk = ~clk;

    run_monitor #(.TIMEOUT_CYC(20)) u_a (
        .clk(clk), .rst(rst), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .retire(retire), .busy(busy_a), .done(done_a),
        .timeout(to_a), .result(res_a),
        .cycle_count(cyc_a), .instr_count(ins_a)
    );

    run_monitor #(.CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .retire(retire), .busy(busy_b), .done(done_b),
        .timeout(to_b), .result(res_b),
        .cycle_count(cyc_b), .instr_count(ins_b)
    );

`ifdef RUN_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam longint CMAX_A = 64'd4294967295;
    localparam longint CMAX_B = 15;

    // st: 0 idle, 1 running, 2 completed, 3 timed out.
    // run/ins are unbounded tallies; saturation applied when compared.
    typedef struct packed {
        int               st;
        longint           run;
        longint           ins;
        logic [1:0][31:0] r;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;
    bit   live = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic longint sat(longint x, longint m);
        return (x > m) ? m : x;
    endfunction

    function automatic mdl_t step(mdl_t m, bit to_en,
                                  longint to_cyc, longint cmax);
        bit fin;
        if (rst) return '0;
        case (m.st)
            0: if (start) m = '{st: 1, run: 0, ins: 0, r: '0};
            1: begin
                fin = wr_en && wr_addr == 5'd1 && wr_data == 32'd1;
                if (wr_en && wr_addr >= 5'd2 && wr_addr <= 5'd3)
                    m.r[int'(wr_addr) - 2] = wr_data;
                m.run++;
                if (retire) m.ins++;
                if (fin) m.st = 2;
                else if (to_en && sat(m.run, cmax) == to_cyc
                         && sat(m.run - 1, cmax) != to_cyc)
                    m.st = 3;
            end
            default: if (start) m = '{st: 1, run: 0, ins: 0, r: '0};
        endcase
        return m;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ma = step(ma, TO_EN, 20, CMAX_A);
        mb = step(mb, TO_EN, 100000, CMAX_B);
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy_a", 64'(busy_a), 64'(ma.st == 1));
            chk("done_a", 64'(done_a), 64'(ma.st == 2));
            chk("to_a",   64'(to_a),   64'(ma.st == 3));
            chk("res_a",  res_a,       ma.r);
            chk("cyc_a",  64'(cyc_a),  64'(sat(ma.run, CMAX_A)));
            chk("ins_a",  64'(ins_a),  64'(sat(ma.ins, CMAX_A)));
            chk("busy_b", 64'(busy_b), 64'(mb.st == 1));
            chk("done_b", 64'(done_b), 64'(mb.st == 2));
            chk("to_b",   64'(to_b),   64'(mb.st == 3));
            chk("res_b",  res_b,       mb.r);
            chk("cyc_b",  64'(cyc_b),  64'(sat(mb.run, CMAX_B)));
            chk("ins_b",  64'(ins_b),  64'(sat(mb.ins, CMAX_B)));
        end
    end

    task automatic go(bit s, bit we, logic [4:0] a,
                      logic [31:0] d, bit r);
        start   = s;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        retire  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 0; wr_en = 0;
        wr_addr = '0; wr_data = '0; retire = 0;
        go(0, 0, 0, 0, 0);
        live = 1'b1;
        go(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_cyc",  64'(cyc_a), 0);
        chk("rst_res",  res_a, 0);

        // basic completion
        go(1, 0, 0, 0, 0);
        chk("arm_busy", 64'(busy_a), 1);
        go(0, 1, 2, 42, 1);
        go(0, 1, 3, 7, 1);
        chk("pre_done", 64'(done_a), 0);
        go(0, 1, 1, 1, 1);
        chk("fin_done",  64'(done_a), 1);
        chk("fin_busy",  64'(busy_a), 0);
        chk("fin_slot0", 64'(res_a[31:0]), 42);
        chk("fin_slot1", 64'(res_a[63:32]), 7);
        chk("fin_ins",   64'(ins_a), 3);
        chk("fin_cyc",   64'(cyc_a), 3);
        go(0, 1, 2, 99, 0);
        chk("frz_slot0", 64'(res_a[31:0]), 42);
        chk("frz_cyc",   64'(cyc_a), 3);

        // re-arm, non-completing marker write, start in RUN, x0 write
        go(1, 0, 0, 0, 0);
        chk("rearm_res",  res_a, 0);
        chk("rearm_cyc",  64'(cyc_a), 0);
        chk("rearm_ins",  64'(ins_a), 0);
        chk("rearm_busy", 64'(busy_a), 1);
        go(0, 1, 1, 5, 1);
        chk("r5_done", 64'(done_a), 0);
        chk("r5_busy", 64'(busy_a), 1);
        go(0, 1, 2, 55, 0);
        go(1, 0, 0, 0, 1);
        go(1, 0, 0, 0, 1);
        chk("st_cyc", 64'(cyc_a), 4);
        chk("st_ins", 64'(ins_a), 3);
        go(0, 1, 0, 123, 0);
        go(0, 1, 1, 1, 0);
        chk("f2_done",  64'(done_a), 1);
        chk("f2_slot0", 64'(res_a[31:0]), 55);
        chk("f2_slot1", 64'(res_a[63:32]), 0);
        chk("f2_cyc",   64'(cyc_a), 6);
        chk("f2_ins",   64'(ins_a), 3);

`ifdef RUN_MONITOR_TIMEOUT_EN
        // completion lands exactly on the limit
        go(1, 0, 0, 0, 0);
        repeat (19) go(0, 0, 0, 0, 0);
        go(0, 1, 1, 1, 0);
        chk("lim_done", 64'(done_a), 1);
        chk("lim_to",   64'(to_a), 0);
        chk("lim_cyc",  64'(cyc_a), 20);
`endif

        // 20 idle RUN cycles: narrow counter saturates
        go(1, 0, 0, 0, 0);
        repeat (20) go(0, 0, 0, 0, 0);
        chk("sat_cyc_b", 64'(cyc_b), 15);
        chk("long_cyc",  64'(cyc_a), 20);
`ifdef RUN_MONITOR_TIMEOUT_EN
        chk("to_high", 64'(to_a), 1);
        chk("to_busy", 64'(busy_a), 0);
        repeat (2) go(0, 0, 0, 0, 0);
        chk("to_hold",     64'(to_a), 1);
        chk("to_hold_cyc", 64'(cyc_a), 20);
`else
        chk("no_to",   64'(to_a), 0);
        chk("no_busy", 64'(busy_a), 1);
`endif

        // reset mid-run, with start held alongside
        rst = 1'b1;
        go(0, 0, 0, 0, 0);
        rst = 1'b0;
        go(1, 0, 0, 0, 0);
        repeat (10) go(0, 0, 0, 0, 1);
        chk("mid_cyc",   64'(cyc_a), 10);
        chk("mid_ins",   64'(ins_a), 10);
        chk("mid_cyc_b", 64'(cyc_b), 10);
        rst = 1'b1;
        go(1, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rr_busy", 64'(busy_a), 0);
        chk("rr_done", 64'(done_a), 0);
        chk("rr_cyc",  64'(cyc_a), 0);
        chk("rr_ins",  64'(ins_a), 0);
        chk("rr_res",  res_a, 0);
        go(0, 0, 0, 0, 0);
        chk("rr_idle", 64'(busy_a), 0);

        live = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
